csr_file: RTL
=============

// Module: csr_file
// PURPOSE
//  Machine-mode CSR storage and the responder side of the CSR read-modify-write path.
//  - Supplies current_csr_val to csr_generator via rd_data.
//  - Commits the generated next_csr_val on writeback.
//  - Owns the trap/mret state updates and the 64-bit cycle/instret counters.
//  - Sits beside the register file in the core; decode drives the address, writeback drives the write.
// PARAMETERS
//  HART_ID      32'h0    value returned by mhartid
//  RESET_MTVEC  32'h0    mtvec reset value (bits[1:0] forced 0)
//  COUNTER_EN   1        0: cycle/instret registers read 0 and ignore writes and increments
// PORTS
//  clk          in   1   core clock
//  reset_n      in   1   async active-low reset
//  rd_addr      in   12  CSR address of the instruction in decode/execute
//  rd_data      out  32  current value of rd_addr (combinational); 0 when illegal
//  rd_illegal   out  1   rd_addr unimplemented, or rd_is_write and rd_addr[11:10]==2'b11
//  rd_is_write  in   1   instruction will write (csrrw/csrrwi, or rs1/uimm != 0)
//  wr_en        in   1   commit wr_data to wr_addr at next edge
//  wr_addr      in   12  write address
//  wr_data      in   32  next_csr_val from csr_generator
//  retire       in   1   one instruction retired this cycle
//  trap_en      in   1   take trap this cycle
//  trap_pc      in   32  PC of the trapping instruction
//  trap_cause   in   32  mcause value
//  mret_en      in   1   mret retires this cycle
//  mtvec_out    out  32  trap vector
//  mepc_out     out  32  return PC
//  mie_out      out  1   mstatus.MIE
// BEHAVIOUR
//  - Reset (async, reset_n low) clears all state to 0, except mtvec, which resets to RESET_MTVEC & ~3.
//    Outputs at reset: mtvec_out=RESET_MTVEC&~3, mepc_out=0, mie_out=0.
//  - Implemented CSRs:
//    mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] reads 2'b11, other bits read 0.
//    mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
//    mcycle/minstret 0xB00/0xB02, mcycleh/minstreth 0xB80/0xB82.
//    Read-only shadows cycle/instret 0xC00/0xC02 and cycleh/instreth 0xC80/0xC82.
//    mhartid 0xF14 (read-only).
//  - Reads are combinational from current state. A write at the edge becomes visible the next cycle;
//    a same-cycle read returns the old value.
//  - Illegal write (unimplemented address, or address[11:10]==2'b11) is dropped and leaves no state change.
//  - Write masks:
//    mtvec and mepc force bits[1:0] to 0.
//    mstatus stores only bits 3 and 7.
//  - Counters:
//    mcycle increments every cycle; minstret increments when retire=1.
//    Both are 64-bit and wrap from 2^64-1 to 0.
//    A write to either half in the same cycle replaces that half with wr_data and suppresses the increment
//    for that counter in that cycle. No carry goes into the other half.
//  - trap_en:
//    mepc <= trap_pc & ~3, mcause <= trap_cause, MPIE <= MIE, MIE <= 0.
//    minstret does not increment even if retire=1.
//  - mret_en: MIE <= MPIE, MPIE <= 1.
//  - Priority for the same cycle: trap_en > mret_en > wr_en.
//    The losing write is discarded only where it targets a register the winner updates.
//  - COUNTER_EN=0: the counter CSRs stay legal, read 0, and are not written.
// STRUCTURE
//  - defines.sv holds:
//    csr_addr enum for every address above;
//    mstatus bit-index constants (MSTATUS_MIE=3, MSTATUS_MPIE=7);
//    CSR_ADDR_SIZE=12.
//  - Sub-module csr_counter64, instantiated twice (cycle, instret).
//    Inputs: inc, wr_lo, wr_hi, wr_data. Output: 64-bit value. Async active-low reset.
//  - Everything else is a flat always_ff block plus a single always_comb read mux.
// TESTING
//  - Reset: after reset_n deasserts, 0x305 reads RESET_MTVEC&~3, 0x300 reads 0x1800, 0xF14 reads HART_ID.
//  - RMW: write 0x340=0xDEADBEEF; a same-cycle read returns 0; the next cycle reads 0xDEADBEEF.
//    Write 0x341=0x1003; it reads back 0x1000.
//  - Illegal access: write 0xC00=5 and write 0x7FF=1.
//    Both flag rd_illegal, rd_data=0, and no state change.
//  - Trap/mret:
//    With MIE=1, trap_en with pc 0x2006 and cause 0xB gives mepc=0x2004, mcause=0xB, mstatus=0x1880.
//    A following mret gives mstatus=0x1888.
//  - Counter wrap:
//    Write mcycle=0xFFFFFFFF and mcycleh=0xFFFFFFFF; after two cycles both read 0.
//    Write to minstret while retire=1 gives exactly wr_data, not wr_data+1.
//  - Simultaneous events: trap_en+wr_en on 0x341 in the same cycle leaves mepc=trap_pc&~3.
//    Assert reset_n mid-count: all counters read 0 immediately.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared CSR address map, mstatus bit positions and the implemented-address decoder
// for the machine-mode CSR file.
package csr_file_pkg;

  localparam int CSR_ADDR_SIZE = 12;
  localparam int MSTATUS_MIE   = 3;
  localparam int MSTATUS_MPIE  = 7;

  typedef enum logic [CSR_ADDR_SIZE-1:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82,
    CSR_MHARTID   = 12'hF14
  } csr_addr_e;

  function automatic logic csr_implemented(input logic [CSR_ADDR_SIZE-1:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
      CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes precedence over the increment and never carries across.
module csr_file_counter64 (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wr_data_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wr_data_i;
    end else if (wr_hi_i) begin
      cnt_d[63:32] = wr_data_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port for the RMW path, writeback commit,
// trap/mret state updates and the cycle/instret counters.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] RESET_MTVEC = 32'h0,
  parameter bit          COUNTER_EN  = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [CSR_ADDR_SIZE-1:0] rd_addr_i,
  output logic [31:0]              rd_data_o,
  output logic                     rd_illegal_o,
  input  logic                     rd_is_write_i,
  input  logic                     wr_en_i,
  input  logic [CSR_ADDR_SIZE-1:0] wr_addr_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     retire_i,
  input  logic                     trap_en_i,
  input  logic [31:0]              trap_pc_i,
  input  logic [31:0]              trap_cause_i,
  input  logic                     mret_en_i,
  output logic [31:0]              mtvec_o,
  output logic [31:0]              mepc_o,
  output logic                     mie_o
);

  localparam logic CNT_EN = COUNTER_EN;

  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic        mie_q, mpie_q;
  logic [63:0] cycle_val, instret_val, cycle_rd, instret_rd;
  logic        wr_ok, rd_impl;

  assign wr_ok = wr_en_i && csr_implemented(wr_addr_i) && (wr_addr_i[11:10] != 2'b11);

  csr_file_counter64 u_cycle (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (CNT_EN),
    .wr_lo_i   (CNT_EN && wr_ok && (wr_addr_i == CSR_MCYCLE)),
    .wr_hi_i   (CNT_EN && wr_ok && (wr_addr_i == CSR_MCYCLEH)),
    .wr_data_i (wr_data_i),
    .value_o   (cycle_val)
  );

  // A trapping instruction does not count as retired.
  csr_file_counter64 u_instret (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (CNT_EN && retire_i && !trap_en_i),
    .wr_lo_i   (CNT_EN && wr_ok && (wr_addr_i == CSR_MINSTRET)),
    .wr_hi_i   (CNT_EN && wr_ok && (wr_addr_i == CSR_MINSTRETH)),
    .wr_data_i (wr_data_i),
    .value_o   (instret_val)
  );

  assign cycle_rd   = CNT_EN ? cycle_val : 64'd0;
  assign instret_rd = CNT_EN ? instret_val : 64'd0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mtvec_q    <= RESET_MTVEC & ~32'd3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
    end else begin
      if (trap_en_i) begin
        mepc_q   <= trap_pc_i & ~32'd3;
        mcause_q <= trap_cause_i;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret_en_i) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
      // Writeback only loses on registers the trap/mret actually touches.
      if (wr_ok && wr_addr_i == CSR_MTVEC)    mtvec_q    <= wr_data_i & ~32'd3;
      if (wr_ok && wr_addr_i == CSR_MSCRATCH) mscratch_q <= wr_data_i;
      if (wr_ok && wr_addr_i == CSR_MEPC && !trap_en_i)   mepc_q   <= wr_data_i & ~32'd3;
      if (wr_ok && wr_addr_i == CSR_MCAUSE && !trap_en_i) mcause_q <= wr_data_i;
      if (wr_ok && wr_addr_i == CSR_MSTATUS && !trap_en_i && !mret_en_i) begin
        mie_q  <= wr_data_i[MSTATUS_MIE];
        mpie_q <= wr_data_i[MSTATUS_MPIE];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_impl   = 1'b1;
    case (rd_addr_i)
      CSR_MSTATUS:               rd_data_o = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      CSR_MTVEC:                 rd_data_o = mtvec_q;
      CSR_MSCRATCH:              rd_data_o = mscratch_q;
      CSR_MEPC:                  rd_data_o = mepc_q;
      CSR_MCAUSE:                rd_data_o = mcause_q;
      CSR_MCYCLE, CSR_CYCLE:     rd_data_o = cycle_rd[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   rd_data_o = cycle_rd[63:32];
      CSR_MINSTRET, CSR_INSTRET: rd_data_o = instret_rd[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_data_o = instret_rd[63:32];
      CSR_MHARTID:               rd_data_o = HART_ID;
      default:                   rd_impl   = 1'b0;
    endcase
    rd_illegal_o = !rd_impl || (rd_is_write_i && (rd_addr_i[11:10] == 2'b11));
    if (rd_illegal_o) rd_data_o = '0;
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule
